ap_ctrl_perf_monitor: RTL and testbench

- Synthesizable, parametrised successor to the single-module ap_ctrl status monitor.
- Passively observes NUM_CH ap_ctrl_chain handshake groups (ap_start/ap_ready/ap_done/ap_continue) of HLS kernel instances. It never drives them.
- Keeps per-channel transaction, latency, stall and protocol-error statistics, readable through a 1-cycle-latency select port.
- Freezes all statistics on `finish`, so cosim benches and on-chip debug read a consistent snapshot.

---
 rtl/ap_ctrl_perf_monitor_pkg.sv | 31 +++
 rtl/ap_ctrl_perf_monitor_if.sv | 38 +++
 rtl/ap_ctrl_perf_monitor_ch_monitor.sv | 89 ++++++++
 rtl/ap_ctrl_perf_monitor.sv | 82 ++++++++
 tb/tb_ap_ctrl_perf_monitor.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ap_ctrl_perf_monitor_pkg.sv
// Shared types and helpers for the ap_ctrl performance monitor.
// Statistics travel at the widest supported width; each channel saturates at its own CNT_W.
package ap_mon_pkg;
  localparam int STAT_W     = 32;
  localparam int OUTS_W_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [STAT_W-1:0]     txn_count;
    logic [STAT_W-1:0]     last_lat;
    logic [STAT_W-1:0]     max_lat;
    logic [STAT_W-1:0]     stall_cycles;
    logic [OUTS_W_MAX-1:0] outstanding;
    ch_state_e             state;
    logic                  err;
  } ch_stats_t;

  function automatic logic [STAT_W-1:0] cnt_max(input int w);
    return {STAT_W{1'b1}} >> (STAT_W - w);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val,
                                                input logic [STAT_W-1:0] lim);
    return (val >= lim) ? val : val + STAT_W'(1);
  endfunction
endpackage

// File: rtl/ap_ctrl_perf_monitor_if.sv
// Observed ap_ctrl_chain handshakes plus the statistics read port of the monitor.
interface ap_ctrl_perf_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int OUT_W  = 4
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              finish;
  logic [NUM_CH-1:0] mon_ap_start;
  logic [NUM_CH-1:0] mon_ap_ready;
  logic [NUM_CH-1:0] mon_ap_done;
  logic [NUM_CH-1:0] mon_ap_continue;
  logic              rd_en;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_txn_count;
  logic [CNT_W-1:0]  rd_last_lat;
  logic [CNT_W-1:0]  rd_max_lat;
  logic [CNT_W-1:0]  rd_stall_cycles;
  logic [OUT_W-1:0]  rd_outstanding;
  logic [1:0]        rd_state;
  logic [NUM_CH-1:0] err_flags;
  logic              all_idle;
  logic              frozen;

  modport master (
    output finish, mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue, rd_en, rd_sel,
    input  rd_valid, rd_txn_count, rd_last_lat, rd_max_lat, rd_stall_cycles,
           rd_outstanding, rd_state, err_flags, all_idle, frozen
  );

  modport slave (
    input  finish, mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue, rd_en, rd_sel,
    output rd_valid, rd_txn_count, rd_last_lat, rd_max_lat, rd_stall_cycles,
           rd_outstanding, rd_state, err_flags, all_idle, frozen
  );
endinterface

// File: rtl/ap_ctrl_perf_monitor_ch_monitor.sv
// One channel: outstanding count, latency timer, saturating statistics and the IDLE/BUSY/DRAIN FSM.
import ap_mon_pkg::*;

module ap_ctrl_ch_monitor #(
  parameter int CNT_W = 32,
  parameter int OUT_W = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_freeze,
  input  logic      i_start,
  input  logic      i_ready,
  input  logic      i_done,
  input  logic      i_continue,
  output ch_stats_t o_stats
);
  localparam logic [STAT_W-1:0] CNT_MAX  = cnt_max(CNT_W);
  localparam logic [OUT_W-1:0]  OUTS_MAX = '1;

  ch_state_e          r_state;
  logic [OUT_W-1:0]   r_outs;
  logic [STAT_W-1:0]  r_lat, r_txn, r_last, r_max, r_stall;
  logic               r_err;

  logic               w_s, w_d, w_stall, w_d_ok, w_err;
  logic [OUT_W-1:0]   w_outs_nxt;
  logic [STAT_W-1:0]  w_lat_meas;

  always_comb begin
    w_s        = i_start & i_ready;
    w_d        = i_done & i_continue;
    w_stall    = i_done & ~i_continue;
    w_d_ok     = w_d & ((r_outs != '0) | w_s);
    // a start and done on the same edge with nothing in flight took zero cycles
    w_lat_meas = (r_outs == '0) ? '0 : r_lat;
    w_outs_nxt = r_outs;
    w_err      = 1'b0;
    if (w_s && !w_d) begin
      if (r_outs == OUTS_MAX) w_err = 1'b1;
      else                    w_outs_nxt = r_outs + OUT_W'(1);
    end else if (w_d && !w_s) begin
      if (r_outs == '0) w_err = 1'b1;
      else              w_outs_nxt = r_outs - OUT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_outs  <= '0;
      r_lat   <= '0;
      r_txn   <= '0;
      r_last  <= '0;
      r_max   <= '0;
      r_stall <= '0;
      r_err   <= 1'b0;
    end else if (!i_freeze) begin
      r_outs <= w_outs_nxt;
      r_err  <= r_err | w_err;
      if (w_stall) r_stall <= sat_inc(r_stall, CNT_MAX);
      if (w_d_ok) begin
        r_txn  <= sat_inc(r_txn, CNT_MAX);
        r_last <= w_lat_meas;
        if (w_lat_meas > r_max) r_max <= w_lat_meas;
      end
      if ((w_s && r_outs == '0) || (w_d_ok && w_outs_nxt != '0)) r_lat <= STAT_W'(1);
      else if (r_outs != '0)                                    r_lat <= sat_inc(r_lat, CNT_MAX);
      case (r_state)
        ST_IDLE:  if (w_outs_nxt != '0) r_state <= ST_BUSY;
        ST_BUSY:  if (w_outs_nxt == '0) r_state <= ST_IDLE;
                  else if (w_stall)     r_state <= ST_DRAIN;
        ST_DRAIN: if (w_outs_nxt == '0) r_state <= ST_IDLE;
                  else if (w_d)         r_state <= ST_BUSY;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_stats              = '0;
    o_stats.txn_count    = r_txn;
    o_stats.last_lat     = r_last;
    o_stats.max_lat      = r_max;
    o_stats.stall_cycles = r_stall;
    o_stats.outstanding  = OUTS_W_MAX'(r_outs);
    o_stats.state        = r_state;
    o_stats.err          = r_err;
  end
endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Passive multi-channel ap_ctrl_chain monitor: per-channel stats, sticky freeze and registered read port.
import ap_mon_pkg::*;

module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int OUT_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  ap_ctrl_perf_monitor_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  ch_stats_t         w_stats [NUM_CH];
  ch_stats_t         w_sel;
  logic [NUM_CH-1:0] w_idle, w_err;

  logic              r_frozen, r_rd_valid, r_all_idle;
  logic [CNT_W-1:0]  r_rd_txn, r_rd_last, r_rd_max, r_rd_stall;
  logic [OUT_W-1:0]  r_rd_outs;
  logic [1:0]        r_rd_state;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_ctrl_ch_monitor #(.CNT_W(CNT_W), .OUT_W(OUT_W)) u_ch (
      .i_clk      (clock),
      .i_rst      (reset),
      .i_freeze   (r_frozen),
      .i_start    (bus.mon_ap_start[g]),
      .i_ready    (bus.mon_ap_ready[g]),
      .i_done     (bus.mon_ap_done[g]),
      .i_continue (bus.mon_ap_continue[g]),
      .o_stats    (w_stats[g])
    );
    assign w_idle[g] = (w_stats[g].state == ST_IDLE);
    assign w_err[g]  = w_stats[g].err;
  end

  // unmatched selects fall through to the all-zero default
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.rd_sel == SEL_W'(i)) w_sel = w_stats[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frozen   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_all_idle <= 1'b1;
      r_rd_txn   <= '0;
      r_rd_last  <= '0;
      r_rd_max   <= '0;
      r_rd_stall <= '0;
      r_rd_outs  <= '0;
      r_rd_state <= '0;
    end else begin
      if (bus.finish) r_frozen <= 1'b1;
      r_rd_valid <= bus.rd_en;
      r_all_idle <= &w_idle;
      if (bus.rd_en) begin
        r_rd_txn   <= w_sel.txn_count[CNT_W-1:0];
        r_rd_last  <= w_sel.last_lat[CNT_W-1:0];
        r_rd_max   <= w_sel.max_lat[CNT_W-1:0];
        r_rd_stall <= w_sel.stall_cycles[CNT_W-1:0];
        r_rd_outs  <= w_sel.outstanding[OUT_W-1:0];
        r_rd_state <= w_sel.state;
      end
    end
  end

  assign bus.rd_valid        = r_rd_valid;
  assign bus.rd_txn_count    = r_rd_txn;
  assign bus.rd_last_lat     = r_rd_last;
  assign bus.rd_max_lat      = r_rd_max;
  assign bus.rd_stall_cycles = r_rd_stall;
  assign bus.rd_outstanding  = r_rd_outs;
  assign bus.rd_state        = r_rd_state;
  assign bus.err_flags       = w_err;
  assign bus.all_idle        = r_all_idle;
  assign bus.frozen          = r_frozen;
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench: a table of single transactions plus hand-written multi-cycle sequences.
module tb_ap_ctrl_perf_monitor;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  ap_ctrl_perf_monitor_if #(.NUM_CH(4), .CNT_W(32), .OUT_W(4)) bus ();
  ap_ctrl_perf_monitor_if #(.NUM_CH(1), .CNT_W(4),  .OUT_W(4)) sbus ();

  ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32), .OUT_W(4)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  ap_ctrl_perf_monitor #(.NUM_CH(1), .CNT_W(4), .OUT_W(4)) dut_small (
    .clock(clock), .reset(reset), .bus(sbus));

  typedef struct {
    int ch; int lat; int st;
    int txn; int last; int mx; int stall;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic rd_main(input int ch);
    bus.rd_en  = 1'b1;
    bus.rd_sel = 2'(ch);
    @(negedge clock);
    bus.rd_en  = 1'b0;
    chk("rd_valid", longint'(bus.rd_valid), 1);
  endtask

  task automatic rd_small(input int sel);
    sbus.rd_en  = 1'b1;
    sbus.rd_sel = 1'(sel);
    @(negedge clock);
    sbus.rd_en  = 1'b0;
    chk("small_rd_valid", longint'(sbus.rd_valid), 1);
  endtask

  // start lands on edge e0, done+continue on edge e0+lat, preceded by st stall edges
  task automatic run_txn(input int ch, input int lat, input int st);
    bus.mon_ap_start[ch] = 1'b1; bus.mon_ap_ready[ch] = 1'b1;
    @(negedge clock);
    bus.mon_ap_start[ch] = 1'b0; bus.mon_ap_ready[ch] = 1'b0;
    repeat (lat - 1 - st) @(negedge clock);
    bus.mon_ap_done[ch] = 1'b1; bus.mon_ap_continue[ch] = 1'b0;
    repeat (st) @(negedge clock);
    bus.mon_ap_continue[ch] = 1'b1;
    @(negedge clock);
    bus.mon_ap_done[ch] = 1'b0; bus.mon_ap_continue[ch] = 1'b0;
  endtask

  task automatic small_txn(input int lat);
    sbus.mon_ap_start = 1'b1; sbus.mon_ap_ready = 1'b1;
    @(negedge clock);
    sbus.mon_ap_start = 1'b0; sbus.mon_ap_ready = 1'b0;
    repeat (lat - 1) @(negedge clock);
    sbus.mon_ap_done = 1'b1; sbus.mon_ap_continue = 1'b1;
    @(negedge clock);
    sbus.mon_ap_done = 1'b0; sbus.mon_ap_continue = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ch:0, lat:15, st:0, txn:1, last:15, mx:15, stall:0};
    vecs[1] = '{ch:1, lat:10, st:7, txn:1, last:10, mx:10, stall:7};
    vecs[2] = '{ch:0, lat:5,  st:0, txn:2, last:5,  mx:15, stall:0};
    vecs[3] = '{ch:1, lat:3,  st:2, txn:2, last:3,  mx:10, stall:9};
    vecs[4] = '{ch:3, lat:30, st:4, txn:1, last:30, mx:30, stall:4};
    vecs[5] = '{ch:0, lat:1,  st:0, txn:3, last:1,  mx:15, stall:0};

    bus.finish = 0; bus.mon_ap_start = '0; bus.mon_ap_ready = '0;
    bus.mon_ap_done = '0; bus.mon_ap_continue = '0; bus.rd_en = 0; bus.rd_sel = '0;
    sbus.finish = 0; sbus.mon_ap_start = '0; sbus.mon_ap_ready = '0;
    sbus.mon_ap_done = '0; sbus.mon_ap_continue = '0; sbus.rd_en = 0; sbus.rd_sel = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("reset_rd_valid", longint'(bus.rd_valid), 0);
    chk("reset_all_idle", longint'(bus.all_idle), 1);
    chk("reset_frozen", longint'(bus.frozen), 0);
    chk("reset_err_flags", longint'(bus.err_flags), 0);
    chk("reset_txn", longint'(bus.rd_txn_count), 0);

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].ch, vecs[v].lat, vecs[v].st);
      rd_main(vecs[v].ch);
      chk($sformatf("v%0d_txn", v), longint'(bus.rd_txn_count), vecs[v].txn);
      chk($sformatf("v%0d_last", v), longint'(bus.rd_last_lat), vecs[v].last);
      chk($sformatf("v%0d_max", v), longint'(bus.rd_max_lat), vecs[v].mx);
      chk($sformatf("v%0d_stall", v), longint'(bus.rd_stall_cycles), vecs[v].stall);
      chk($sformatf("v%0d_outs", v), longint'(bus.rd_outstanding), 0);
      chk($sformatf("v%0d_state", v), longint'(bus.rd_state), 0);
      chk($sformatf("v%0d_all_idle", v), longint'(bus.all_idle), 1);
    end
    chk("table_err_flags", longint'(bus.err_flags), 0);

    // backpressure on ch1: IDLE -> BUSY -> DRAIN -> IDLE
    bus.mon_ap_start[1] = 1; bus.mon_ap_ready[1] = 1;
    @(negedge clock);
    bus.mon_ap_start[1] = 0; bus.mon_ap_ready[1] = 0;
    @(negedge clock);
    rd_main(1);
    chk("bp_state_busy", longint'(bus.rd_state), 1);
    bus.mon_ap_done[1] = 1; bus.mon_ap_continue[1] = 0;
    @(negedge clock);
    rd_main(1);
    chk("bp_state_drain", longint'(bus.rd_state), 2);
    bus.mon_ap_continue[1] = 1;
    @(negedge clock);
    bus.mon_ap_done[1] = 0; bus.mon_ap_continue[1] = 0;
    rd_main(1);
    chk("bp_state_idle", longint'(bus.rd_state), 0);
    chk("bp_txn", longint'(bus.rd_txn_count), 3);
    chk("bp_stall", longint'(bus.rd_stall_cycles), 11);
    chk("bp_last", longint'(bus.rd_last_lat), 5);

    // pipelined overlap on ch2: starts on e0..e2, dones on e20..e22
    bus.mon_ap_start[2] = 1; bus.mon_ap_ready[2] = 1;
    repeat (3) @(negedge clock);
    bus.mon_ap_start[2] = 0; bus.mon_ap_ready[2] = 0;
    rd_main(2);
    chk("ovl_outs_peak", longint'(bus.rd_outstanding), 3);
    chk("ovl_all_idle_busy", longint'(bus.all_idle), 0);
    repeat (16) @(negedge clock);
    bus.mon_ap_done[2] = 1; bus.mon_ap_continue[2] = 1;
    repeat (3) @(negedge clock);
    bus.mon_ap_done[2] = 0; bus.mon_ap_continue[2] = 0;
    rd_main(2);
    chk("ovl_txn", longint'(bus.rd_txn_count), 3);
    chk("ovl_max", longint'(bus.rd_max_lat), 20);
    chk("ovl_last", longint'(bus.rd_last_lat), 1);
    chk("ovl_outs_end", longint'(bus.rd_outstanding), 0);

    // protocol errors on ch3: orphan done, then 16 starts against a 4-bit counter
    bus.mon_ap_done[3] = 1; bus.mon_ap_continue[3] = 1;
    @(negedge clock);
    bus.mon_ap_done[3] = 0; bus.mon_ap_continue[3] = 0;
    rd_main(3);
    chk("err_flag3", longint'(bus.err_flags), 4'b1000);
    chk("err_txn_unchanged", longint'(bus.rd_txn_count), 1);
    chk("err_outs_zero", longint'(bus.rd_outstanding), 0);
    bus.mon_ap_start[3] = 1; bus.mon_ap_ready[3] = 1;
    repeat (16) @(negedge clock);
    bus.mon_ap_start[3] = 0; bus.mon_ap_ready[3] = 0;
    rd_main(3);
    chk("ovf_outs_max", longint'(bus.rd_outstanding), 15);
    chk("ovf_err_sticky", longint'(bus.err_flags), 4'b1000);
    chk("ovf_state_busy", longint'(bus.rd_state), 1);

    // freeze during an open ch0 transaction
    bus.mon_ap_start[0] = 1; bus.mon_ap_ready[0] = 1;
    @(negedge clock);
    bus.mon_ap_start[0] = 0; bus.mon_ap_ready[0] = 0;
    repeat (3) @(negedge clock);
    bus.finish = 1;
    @(negedge clock);
    bus.finish = 0;
    chk("frozen_set", longint'(bus.frozen), 1);
    for (int i = 0; i < 100; i++) begin
      bus.mon_ap_start[0] = (i % 3 == 0); bus.mon_ap_ready[0] = 1;
      bus.mon_ap_done[0] = (i % 4 == 0); bus.mon_ap_continue[0] = (i % 8 == 0);
      bus.mon_ap_done[3] = 1; bus.mon_ap_continue[3] = (i % 2 == 0);
      @(negedge clock);
    end
    bus.mon_ap_start = '0; bus.mon_ap_ready = '0; bus.mon_ap_done = '0; bus.mon_ap_continue = '0;
    rd_main(0);
    chk("frz_txn", longint'(bus.rd_txn_count), 3);
    chk("frz_last", longint'(bus.rd_last_lat), 1);
    chk("frz_stall", longint'(bus.rd_stall_cycles), 0);
    chk("frz_outs", longint'(bus.rd_outstanding), 1);
    chk("frz_state", longint'(bus.rd_state), 1);
    rd_main(3);
    chk("frz_ch3_outs", longint'(bus.rd_outstanding), 15);
    chk("frz_ch3_stall", longint'(bus.rd_stall_cycles), 4);
    chk("frz_err_flags", longint'(bus.err_flags), 4'b1000);
    chk("frz_still", longint'(bus.frozen), 1);

    // asynchronous reset between edges
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_outs", longint'(bus.rd_outstanding), 0);
    chk("arst_stall", longint'(bus.rd_stall_cycles), 0);
    chk("arst_valid", longint'(bus.rd_valid), 0);
    chk("arst_frozen", longint'(bus.frozen), 0);
    chk("arst_err", longint'(bus.err_flags), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("arst_all_idle", longint'(bus.all_idle), 1);
    rd_main(3);
    chk("arst_ch3_txn", longint'(bus.rd_txn_count), 0);
    chk("arst_ch3_state", longint'(bus.rd_state), 0);

    // saturation on the CNT_W=4 instance
    for (int t = 0; t < 19; t++) small_txn(2);
    small_txn(20);
    rd_small(0);
    chk("sat_txn", longint'(sbus.rd_txn_count), 15);
    chk("sat_last", longint'(sbus.rd_last_lat), 15);
    chk("sat_max", longint'(sbus.rd_max_lat), 15);
    chk("sat_state", longint'(sbus.rd_state), 0);
    rd_small(1);
    chk("oor_txn", longint'(sbus.rd_txn_count), 0);
    chk("oor_max", longint'(sbus.rd_max_lat), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
